fpadd_rr_sched: RTL and testbench
=================================

// Module: fpadd_rr_sched
// PURPOSE
//  Round-robin scheduler that time-shares one pipelined fpadd_single among NUM_REQ requesters.
//  Accepts at most one operand pair per cycle and drives it into the adder (fpu_a/fpu_b -> reg_A/reg_B).
//  Carries a requester-ID tag alongside the adder's fixed latency and returns each result with its ID.
//  Sits between the requesting engines and the single adder instance.
// PARAMETERS
//  NUM_REQ  4  number of requesters, >=2
//  FPU_LAT  2  clk edges from operands presented at adder inputs to result on adder out
//  ID_W     $clog2(NUM_REQ)  localparam, requester-ID width
// PORTS
//  clk        in   1            clock, rising edge
//  reset      in   1            synchronous, active-high
//  req_valid  in   NUM_REQ      per-requester request valid
//  req_a      in   NUM_REQ*32   operand A, requester i at [32*i+31:32*i]
//  req_b      in   NUM_REQ*32   operand B, same packing
//  req_ready  out  NUM_REQ      one-hot grant, combinational from req_valid and rr pointer
//  fpu_a      out  32           to adder reg_A
//  fpu_b      out  32           to adder reg_B
//  fpu_out    in   32           from adder out
//  rsp_valid  out  1            result valid (single cycle, no backpressure)
//  rsp_id     out  ID_W         requester that issued the result
//  rsp_data   out  32           result, equal to fpu_out in the rsp_valid cycle
//  inflight   out  $clog2(FPU_LAT+1)  number of valid tags in the tag pipe
// BEHAVIOUR
//  Clock and reset
//   - Reset is synchronous: state is cleared on the clk edge where reset=1.
//   - Reset values: ptr=0, tag pipe all invalid, rsp_valid=0, rsp_id=0, inflight=0.
//   - req_ready=0 while reset=1. fpu_a and fpu_b are 0 when nothing is granted.
//  Arbitration
//   - Search order starts at ptr and wraps modulo NUM_REQ. The first i with req_valid[i]=1 gets req_ready[i]=1.
//   - At most one grant per cycle.
//   - A transfer happens when req_valid[i]&req_ready[i]=1 at the clk edge.
//   - After a transfer to i, ptr <= (i+1) mod NUM_REQ. With no transfer, ptr holds.
//   - The adder accepts every cycle, so a valid requester waits at most NUM_REQ-1 cycles.
//  Requester obligations
//   - req_a, req_b and req_valid must stay stable until the transfer.
//   - Deasserting req_valid before the grant is allowed; that request is dropped with no effect.
//  Issue timing
//   - In the grant cycle t, fpu_a/fpu_b are a combinational mux of the granted requester's operands.
//   - The adder captures them at the edge ending cycle t.
//  Tag pipe
//   - FPU_LAT stages of {valid, id}. Stage0 <= {transfer, granted id}; each later stage shifts by one every cycle.
//   - rsp_valid = last-stage valid. rsp_id = last-stage id. rsp_data = fpu_out.
//   - rsp_valid is therefore high in cycle t+FPU_LAT.
//   - Responses come out in issue order. Throughput is 1 result per cycle.
//  inflight
//   - Popcount of tag-pipe valids, range 0..FPU_LAT.
//   - It increments and decrements in the same cycle on simultaneous issue and retire.
//  Reset mid-operation
//   - All in-flight tags are discarded and no rsp_valid is produced for them.
//   - The adder's stale output is ignored.
//  ID encoding
//   - ID_W-bit binary. NUM_REQ need not be a power of two; pointer wrap is explicit at NUM_REQ-1.
// STRUCTURE
//  Shared package fpadd_pkg holds:
//   - FP_W=32
//   - FPADD_LAT=2 (default for FPU_LAT, matching fpadd_single)
//   - typedef fp_word_t
//  Sub-module rr_arbiter (NUM_REQ): inputs req, ptr; outputs one-hot gnt and binary gnt_id.
//  The tag pipe and operand mux stay in this module. fpadd_single is instantiated by the parent, not here.
// TESTING (bench instantiates fpadd_rr_sched + fpadd_single, NUM_REQ=4, FPU_LAT=2)
//  1. Only req1 valid, A=3F800000, B=40000000 -> req_ready=0010 same cycle; 2 cycles later rsp_valid=1, rsp_id=1, rsp_data=40400000.
//  2. All 4 valid continuously -> grants 0,1,2,3,0,1... one per cycle; rsp_id follows 0,1,2,3 delayed 2 cycles; inflight=2 at steady state.
//  3. req2 alone, 5 back-to-back ops -> 5 grants in 5 consecutive cycles; 5 consecutive rsp_valid, all rsp_id=2.
//  4. Last grant to req3, then req0 and req3 valid together -> req_ready=0001 (wrap), next cycle req3 granted.
//  5. Issue 2 ops, assert reset 1 cycle -> rsp_valid stays 0 for the following 3 cycles, inflight=0, next single request from req3 is granted first.
//  6. req0 A=40400000, B=C0400000 -> rsp_id=0, rsp_data=00000000; req_valid pulsed low before grant -> no issue, inflight unchanged.

Source files
------------

// File: rtl/fpadd_pkg.sv
// Shared types and constants for the single-precision adder and its scheduler.
package fpadd_pkg;

  localparam int unsigned FP_W      = 32;
  localparam int unsigned FPADD_LAT = 2;

  typedef logic [FP_W-1:0] fp_word_t;

  localparam fp_word_t FP_QNAN = 32'h7FC0_0000;

endpackage

// File: rtl/fpadd_single.sv
// Two-stage IEEE-754 single adder, round-to-nearest-even, denormals flushed to zero.
module fpadd_single
  import fpadd_pkg::*;
(
  input  logic     clk,
  input  fp_word_t reg_A,
  input  fp_word_t reg_B,
  output fp_word_t out
);

  // Stage 1: unpack, order by magnitude, align the smaller operand.
  logic        sa, sb, a_big;
  logic [7:0]  ea, eb, big_e, small_e, d;
  logic [22:0] ma, mb, big_mn, small_mn;
  logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic [26:0] big_m, small_full, small_al;
  logic        spec;
  fp_word_t    spec_val;

  assign sa = reg_A[31];
  assign sb = reg_B[31];
  assign ea = reg_A[30:23];
  assign eb = reg_B[30:23];
  assign ma = reg_A[22:0];
  assign mb = reg_B[22:0];

  assign a_nan  = (ea == 8'hFF) && (ma != '0);
  assign b_nan  = (eb == 8'hFF) && (mb != '0);
  assign a_inf  = (ea == 8'hFF) && (ma == '0);
  assign b_inf  = (eb == 8'hFF) && (mb == '0);
  assign a_zero = (ea == 8'h00);
  assign b_zero = (eb == 8'h00);

  always_comb begin
    a_big      = ({ea, ma} >= {eb, mb});
    big_e      = a_big ? ea : eb;
    small_e    = a_big ? eb : ea;
    big_mn     = a_big ? ma : mb;
    small_mn   = a_big ? mb : ma;
    d          = big_e - small_e;
    big_m      = {1'b1, big_mn, 3'b000};
    small_full = {1'b1, small_mn, 3'b000};
    // Bits shifted past the guard positions collapse into the sticky LSB.
    if (d >= 8'd27) begin
      small_al = 27'd1;
    end else begin
      small_al = (small_full >> d)
               | {26'd0, |(small_full & ~(27'h7FF_FFFF << d))};
    end
  end

  always_comb begin
    spec     = 1'b1;
    spec_val = '0;
    if (a_nan || b_nan)       spec_val = FP_QNAN;
    else if (a_inf && b_inf)  spec_val = (sa == sb) ? reg_A : FP_QNAN;
    else if (a_inf)           spec_val = reg_A;
    else if (b_inf)           spec_val = reg_B;
    else if (a_zero && b_zero) spec_val = {sa & sb, 31'd0};
    else if (a_zero)          spec_val = reg_B;
    else if (b_zero)          spec_val = reg_A;
    else                      spec     = 1'b0;
  end

  logic        spec_q, sign_q, sub_q;
  fp_word_t    spec_val_q;
  logic [7:0]  exp_q;
  logic [26:0] big_q, small_q;

  always_ff @(posedge clk) begin
    spec_q     <= spec;
    spec_val_q <= spec_val;
    sign_q     <= a_big ? sa : sb;
    sub_q      <= sa ^ sb;
    exp_q      <= big_e;
    big_q      <= big_m;
    small_q    <= small_al;
  end

  // Stage 2: add/subtract, normalise, round.
  logic [27:0]        sum;
  logic [26:0]        norm;
  logic [4:0]         lz;
  logic               found;
  logic signed [9:0]  exp_n, exp_r;
  logic [23:0]        mant;
  logic               up;
  logic [24:0]        mant_r;
  logic [22:0]        frac;
  fp_word_t           result;

  always_comb begin
    sum   = sub_q ? ({1'b0, big_q} - {1'b0, small_q}) : ({1'b0, big_q} + {1'b0, small_q});
    lz    = '0;
    found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!found && sum[i]) begin
        lz    = 5'(26 - i);
        found = 1'b1;
      end
    end
    if (sum[27]) begin
      norm  = sum[27:1] | {26'd0, sum[0]};
      exp_n = $signed({2'b00, exp_q}) + 10'sd1;
    end else begin
      norm  = sum[26:0] << lz;
      exp_n = $signed({2'b00, exp_q}) - $signed({5'd0, lz});
    end
    mant   = norm[26:3];
    up     = norm[2] & ((|norm[1:0]) | mant[0]);
    mant_r = {1'b0, mant} + {24'd0, up};
    exp_r  = mant_r[24] ? exp_n + 10'sd1 : exp_n;
    frac   = mant_r[24] ? mant_r[23:1] : mant_r[22:0];

    if (spec_q)                result = spec_val_q;
    else if (sum == '0)        result = '0;
    else if (exp_r <= 10'sd0)  result = {sign_q, 31'd0};
    else if (exp_r >= 10'sd255) result = {sign_q, 8'hFF, 23'd0};
    else                       result = {sign_q, exp_r[7:0], frac};
  end

  always_ff @(posedge clk) begin
    out <= result;
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first requester at or after ptr_i (wrapping) wins.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
  output logic [NUM_REQ-1:0]         gnt_o,
  output logic [$clog2(NUM_REQ)-1:0] gnt_id_o
);

  localparam int unsigned ID_W = $clog2(NUM_REQ);
  localparam int          N    = int'(NUM_REQ);

  logic found;
  int   idx;

  always_comb begin
    gnt_o    = '0;
    gnt_id_o = '0;
    found    = 1'b0;
    idx      = 0;
    for (int off = 0; off < N; off++) begin
      // Wrap is explicit so non-power-of-two NUM_REQ never selects a phantom slot.
      idx = int'(ptr_i) + off;
      if (idx >= N) idx = idx - N;
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        gnt_id_o   = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/fpadd_rr_sched.sv
// Time-shares one pipelined adder among NUM_REQ requesters; a tag pipe matching the
// adder latency returns each result with the ID of the requester that issued it.
module fpadd_rr_sched
  import fpadd_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned FPU_LAT = FPADD_LAT
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*FP_W-1:0]      req_a,
  input  logic [NUM_REQ*FP_W-1:0]      req_b,
  output logic [NUM_REQ-1:0]           req_ready,
  output fp_word_t                     fpu_a,
  output fp_word_t                     fpu_b,
  input  fp_word_t                     fpu_out,
  output logic                         rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
  output fp_word_t                     rsp_data,
  output logic [$clog2(FPU_LAT+1)-1:0] inflight
);

  localparam int unsigned ID_W  = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(FPU_LAT+1);

  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [NUM_REQ-1:0] req_masked;
  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_id;
  logic               xfer;

  logic [FPU_LAT-1:0] vld_q;
  logic [ID_W-1:0]    id_q [FPU_LAT];
  logic [CNT_W-1:0]   cnt;

  // No grants while reset is held so nothing can slip into the cleared pipe.
  assign req_masked = reset ? '0 : req_valid;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req_i    (req_masked),
    .ptr_i    (ptr_q),
    .gnt_o    (gnt),
    .gnt_id_o (gnt_id)
  );

  assign req_ready = gnt;
  assign xfer      = |gnt;

  always_comb begin
    fpu_a = '0;
    fpu_b = '0;
    if (xfer) begin
      fpu_a = req_a[FP_W*gnt_id +: FP_W];
      fpu_b = req_b[FP_W*gnt_id +: FP_W];
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (xfer) begin
      ptr_d = (gnt_id == ID_W'(NUM_REQ-1)) ? '0 : gnt_id + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
      vld_q <= '0;
      for (int i = 0; i < FPU_LAT; i++) id_q[i] <= '0;
    end else begin
      ptr_q    <= ptr_d;
      vld_q[0] <= xfer;
      id_q[0]  <= gnt_id;
      for (int i = 1; i < FPU_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        id_q[i]  <= id_q[i-1];
      end
    end
  end

  always_comb begin
    cnt = '0;
    for (int i = 0; i < FPU_LAT; i++) cnt = cnt + CNT_W'(vld_q[i]);
  end

  assign inflight  = cnt;
  assign rsp_valid = vld_q[FPU_LAT-1];
  assign rsp_id    = id_q[FPU_LAT-1];
  assign rsp_data  = fpu_out;

endmodule

// File: tb/tb_fpadd_rr_sched.sv
// Directed bench: scheduler driving a real fpadd_single, NUM_REQ=4, FPU_LAT=2.
module tb_fpadd_rr_sched;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   req_valid;
  logic [127:0] req_a, req_b;
  logic [3:0]   req_ready;
  logic [31:0]  fpu_a, fpu_b, fpu_out, rsp_data;
  logic         rsp_valid;
  logic [1:0]   rsp_id;
  logic [1:0]   inflight;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] exp_sum [4];
  logic [3:0]  exp_rdy;
  int          cnt;

  always #5 clk = ~clk;

  fpadd_rr_sched #(
    .NUM_REQ (4),
    .FPU_LAT (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .fpu_a     (fpu_a),
    .fpu_b     (fpu_b),
    .fpu_out   (fpu_out),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .inflight  (inflight)
  );

  fpadd_single u_fpu (
    .clk   (clk),
    .reg_A (fpu_a),
    .reg_B (fpu_b),
    .out   (fpu_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset     = 1'b1;
    req_valid = 4'b1111;
    req_a     = '0;
    req_b     = '0;
    mid();
    chk("ready_in_reset", 32'(req_ready), 32'h0);
    nxt();
    reset     = 1'b0;
    req_valid = 4'b0000;
    mid();
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_id", 32'(rsp_id), 32'h0);
    chk("rst_inflight", 32'(inflight), 32'h0);
    chk("rst_fpu_a_idle", fpu_a, 32'h0);
    nxt();

    // 1: single request from req1, 1.0 + 2.0
    req_a[63:32] = 32'h3F80_0000;
    req_b[63:32] = 32'h4000_0000;
    req_valid    = 4'b0010;
    mid();
    chk("t1_ready", 32'(req_ready), 32'h2);
    chk("t1_fpu_a", fpu_a, 32'h3F80_0000);
    chk("t1_fpu_b", fpu_b, 32'h4000_0000);
    nxt();
    req_valid = 4'b0000;
    mid();
    chk("t1_inflight1", 32'(inflight), 32'h1);
    chk("t1_rsp_early", 32'(rsp_valid), 32'h0);
    nxt();
    mid();
    chk("t1_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("t1_rsp_id", 32'(rsp_id), 32'h1);
    chk("t1_rsp_data", rsp_data, 32'h4040_0000);
    nxt();
    mid();
    chk("t1_rsp_done", 32'(rsp_valid), 32'h0);
    chk("t1_inflight0", 32'(inflight), 32'h0);
    nxt();

    // 2: all four valid, pointer restarted at 0 by a reset
    req_a = {32'h3FC0_0000, 32'h4000_0000, 32'h3F80_0000, 32'h3F80_0000};
    req_b = {32'h3F00_0000, 32'h4000_0000, 32'h4000_0000, 32'h3F80_0000};
    exp_sum[0] = 32'h4000_0000;
    exp_sum[1] = 32'h4040_0000;
    exp_sum[2] = 32'h4080_0000;
    exp_sum[3] = 32'h4000_0000;
    reset = 1'b1;
    nxt();
    reset = 1'b0;
    for (int k = 0; k < 9; k++) begin
      req_valid = (k < 6) ? 4'b1111 : 4'b0000;
      exp_rdy   = (k < 6) ? (4'b0001 << (k % 4)) : 4'b0000;
      cnt = 0;
      for (int j = k - 2; j < k; j++) if (j >= 0 && j < 6) cnt++;
      mid();
      chk("t2_ready", 32'(req_ready), 32'(exp_rdy));
      chk("t2_inflight", 32'(inflight), 32'(cnt));
      chk("t2_rsp_valid", 32'(rsp_valid), 32'(k >= 2 && k < 8));
      if (k >= 2 && k < 8) begin
        chk("t2_rsp_id", 32'(rsp_id), 32'((k - 2) % 4));
        chk("t2_rsp_data", rsp_data, exp_sum[(k - 2) % 4]);
      end
      nxt();
    end

    // 3: req2 alone, five back-to-back
    for (int k = 0; k < 7; k++) begin
      req_valid = (k < 5) ? 4'b0100 : 4'b0000;
      mid();
      chk("t3_ready", 32'(req_ready), (k < 5) ? 32'h4 : 32'h0);
      chk("t3_rsp_valid", 32'(rsp_valid), 32'(k >= 2));
      if (k >= 2) begin
        chk("t3_rsp_id", 32'(rsp_id), 32'h2);
        chk("t3_rsp_data", rsp_data, 32'h4080_0000);
      end
      nxt();
    end

    // 4: grant req3, then req0+req3 -> wrap to 0, then req3
    req_valid = 4'b1000;
    mid();
    chk("t4_ready_r3", 32'(req_ready), 32'h8);
    nxt();
    req_valid = 4'b1001;
    mid();
    chk("t4_ready_wrap", 32'(req_ready), 32'h1);
    nxt();
    req_valid = 4'b1000;
    mid();
    chk("t4_ready_r3b", 32'(req_ready), 32'h8);
    chk("t4_rsp_id_a", 32'(rsp_id), 32'h3);
    chk("t4_rsp_data_a", rsp_data, 32'h4000_0000);
    nxt();
    req_valid = 4'b0000;
    mid();
    chk("t4_rsp_id_b", 32'(rsp_id), 32'h0);
    nxt();
    mid();
    chk("t4_rsp_valid_c", 32'(rsp_valid), 32'h1);
    chk("t4_rsp_id_c", 32'(rsp_id), 32'h3);
    nxt();

    // 5: two ops in flight, then reset
    req_valid = 4'b0011;
    mid();
    chk("t5_ready0", 32'(req_ready), 32'h1);
    nxt();
    req_valid = 4'b0010;
    mid();
    chk("t5_ready1", 32'(req_ready), 32'h2);
    nxt();
    reset     = 1'b1;
    req_valid = 4'b1000;
    mid();
    chk("t5_ready_in_reset", 32'(req_ready), 32'h0);
    nxt();
    reset     = 1'b0;
    req_valid = 4'b0000;
    for (int k = 0; k < 3; k++) begin
      mid();
      chk("t5_rsp_flushed", 32'(rsp_valid), 32'h0);
      chk("t5_inflight", 32'(inflight), 32'h0);
      nxt();
    end
    req_valid = 4'b1010;
    mid();
    chk("t5_ptr_reset", 32'(req_ready), 32'h2);
    #1;
    req_valid = 4'b1000;
    #1;
    chk("t5_ready_r3", 32'(req_ready), 32'h8);
    nxt();
    req_valid = 4'b0000;
    mid();
    chk("t5_inflight1", 32'(inflight), 32'h1);
    nxt();
    mid();
    chk("t5_rsp_id", 32'(rsp_id), 32'h3);
    chk("t5_rsp_data", rsp_data, 32'h4000_0000);
    nxt();

    // 6: 3.0 + -3.0 from req0, then a request withdrawn before its grant
    req_a[31:0] = 32'h4040_0000;
    req_b[31:0] = 32'hC040_0000;
    req_valid   = 4'b0001;
    mid();
    chk("t6_ready0", 32'(req_ready), 32'h1);
    chk("t6_fpu_b", fpu_b, 32'hC040_0000);
    nxt();
    req_valid = 4'b0100;
    mid();
    chk("t6_ready_pulse", 32'(req_ready), 32'h4);
    #1;
    req_valid = 4'b0000;
    #1;
    chk("t6_ready_drop", 32'(req_ready), 32'h0);
    nxt();
    mid();
    chk("t6_inflight", 32'(inflight), 32'h1);
    chk("t6_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("t6_rsp_id", 32'(rsp_id), 32'h0);
    chk("t6_rsp_data", rsp_data, 32'h0000_0000);
    nxt();
    req_valid = 4'b0101;
    mid();
    chk("t6_inflight0", 32'(inflight), 32'h0);
    chk("t6_ptr_held", 32'(req_ready), 32'h4);
    nxt();
    req_valid = 4'b0000;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
